// File: rtl/ps2_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_host : PS/2 host port - debounced RX into a FIFO, command TX     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ps2_host #(
    parameter int DEBOUNCE_CYCLES = 255,
    parameter int FIFO_LOG2       = 3,
    parameter int INHIBIT_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES  = 750000
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       ps2_clk_pin,
    input  logic       ps2_data_pin,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error,
    output logic       rx_overflow,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int DBW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int INW   = $clog2(INHIBIT_CYCLES + 1);
    localparam int TOW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FIFO_LOG2:0] FIFO_FULL = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_BITS = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_INHIBIT = 3'd1,
        TX_REQ     = 3'd2,
        TX_BITS    = 3'd3,
        TX_ACK     = 3'd4,
        TX_WAIT    = 3'd5
    } tx_state_t;

    rx_state_t            rx_state, rx_next;
    tx_state_t            tx_state, tx_next;

    logic [1:0]           w_pin_raw;
    logic [1:0]           w_pin_db;
    logic                 w_clk_db;
    logic                 w_data_db;
    logic                 r_clk_prev;
    logic                 w_fall;

    logic [TOW-1:0]       r_to_cnt;
    logic                 w_to_active;
    logic                 w_timeout;

    logic [10:0]          r_rx_shift;
    logic [3:0]           r_rx_cnt;
    logic                 w_rx_shift;
    logic                 w_frame_good;
    logic                 w_push;
    logic                 w_rx_bad;
    logic                 w_rx_to;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2:0]   r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;

    logic                 r_ready_en;
    logic                 w_tx_hs;
    logic [7:0]           r_tx_byte;
    logic                 r_tx_par;
    logic [INW-1:0]       r_inh_cnt;
    logic [3:0]           r_tx_cnt;
    logic                 w_tx_edge;
    logic                 w_tx_ok;
    logic                 w_tx_fail;
    logic                 w_data_oe_next;
    logic                 r_clk_oe;
    logic                 r_data_oe;

    logic                 r_rx_error;
    logic                 r_rx_overflow;
    logic                 r_tx_done;
    logic                 r_tx_error;

    // Two-flop synchroniser followed by a stability counter on each pin.
    assign w_pin_raw = {ps2_data_pin, ps2_clk_pin};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic           r_meta;
            logic           r_sync;
            logic           r_stable;
            logic [DBW-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_low) begin
                if (!reset_low) begin
                    r_meta   <= 1'b1;
                    r_sync   <= 1'b1;
                    r_stable <= 1'b1;
                    r_cnt    <= '0;
                end else begin
                    r_meta <= w_pin_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        r_stable <= r_sync;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + DBW'(1);
                    end
                end
            end

            assign w_pin_db[gi] = r_stable;
        end
    endgenerate

    assign w_clk_db  = w_pin_db[0];
    assign w_data_db = w_pin_db[1];
    assign w_fall    = r_clk_prev & ~w_clk_db;

    // One edge-gap timer serves both FSMs; they are never active together.
    assign w_to_active = (rx_state == RX_BITS) || (tx_state == TX_REQ) ||
                         (tx_state == TX_BITS) || (tx_state == TX_ACK);
    assign w_timeout   = w_to_active && !w_fall &&
                         (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));

    assign w_frame_good = ~r_rx_shift[0] & (^r_rx_shift[9:1]) & r_rx_shift[10];

    assign w_full   = (r_count == FIFO_FULL);
    assign rx_valid = (r_count != '0);
    assign rx_data  = r_mem[r_rd_ptr];
    assign w_pop    = rx_valid & rx_ready;
    assign w_wr     = w_push & (~w_full | w_pop);

    assign tx_ready = r_ready_en && (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
    assign w_tx_hs  = tx_valid & tx_ready;

    // RX FSM: a start edge is refused while TX is busy or being launched.
    always_comb begin
        rx_next    = rx_state;
        w_rx_shift = 1'b0;
        w_push     = 1'b0;
        w_rx_bad   = 1'b0;
        w_rx_to    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (w_fall && (tx_state == TX_IDLE) && !w_tx_hs) begin
                    w_rx_shift = 1'b1;
                    rx_next    = RX_BITS;
                end
            end
            RX_BITS: begin
                if (w_timeout) begin
                    w_rx_to = 1'b1;
                    rx_next = RX_IDLE;
                end else if (w_fall) begin
                    w_rx_shift = 1'b1;
                    if (r_rx_cnt == 4'd10) begin
                        rx_next = RX_DONE;
                    end
                end
            end
            RX_DONE: begin
                w_push   = w_frame_good;
                w_rx_bad = ~w_frame_good;
                rx_next  = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // TX FSM
    always_comb begin
        tx_next        = tx_state;
        w_data_oe_next = 1'b0;
        w_tx_edge      = 1'b0;
        w_tx_ok        = 1'b0;
        w_tx_fail      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (w_tx_hs) begin
                    tx_next = TX_INHIBIT;
                end
            end
            TX_INHIBIT: begin
                if (r_inh_cnt == INW'(INHIBIT_CYCLES - 1)) begin
                    tx_next = TX_REQ;
                end
            end
            TX_REQ: begin
                w_data_oe_next = 1'b1;
                tx_next        = TX_BITS;
            end
            TX_BITS: begin
                w_data_oe_next = r_data_oe;
                if (w_timeout) begin
                    w_data_oe_next = 1'b0;
                    w_tx_fail      = 1'b1;
                    tx_next        = TX_WAIT;
                end else if (w_fall) begin
                    w_tx_edge = 1'b1;
                    if (r_tx_cnt == 4'd9) begin
                        w_data_oe_next = 1'b0;
                        tx_next        = TX_ACK;
                    end else if (r_tx_cnt == 4'd8) begin
                        w_data_oe_next = ~r_tx_par;
                    end else begin
                        w_data_oe_next = ~r_tx_byte[r_tx_cnt[2:0]];
                    end
                end
            end
            TX_ACK: begin
                if (w_timeout) begin
                    w_tx_fail = 1'b1;
                    tx_next   = TX_WAIT;
                end else if (w_fall) begin
                    w_tx_ok   = ~w_data_db;
                    w_tx_fail = w_data_db;
                    tx_next   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (w_clk_db && w_data_db) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_clk_prev    <= 1'b1;
            r_to_cnt      <= '0;
            r_rx_shift    <= '0;
            r_rx_cnt      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ready_en    <= 1'b0;
            r_tx_byte     <= '0;
            r_tx_par      <= 1'b0;
            r_inh_cnt     <= '0;
            r_tx_cnt      <= '0;
            r_clk_oe      <= 1'b0;
            r_data_oe     <= 1'b0;
            r_rx_error    <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_tx_done     <= 1'b0;
            r_tx_error    <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_db;
            r_ready_en <= 1'b1;
            r_to_cnt   <= (!w_to_active || w_fall) ? '0 : r_to_cnt + TOW'(1);

            if (w_rx_shift) begin
                r_rx_shift <= {w_data_db, r_rx_shift[10:1]};
                r_rx_cnt   <= (rx_state == RX_IDLE) ? 4'd1 : r_rx_cnt + 4'd1;
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (w_tx_hs) begin
                r_tx_byte <= tx_data;
                r_tx_par  <= ~^tx_data;
            end
            r_inh_cnt <= (tx_state == TX_INHIBIT) ? r_inh_cnt + INW'(1) : '0;
            if (tx_state != TX_BITS) begin
                r_tx_cnt <= '0;
            end else if (w_tx_edge) begin
                r_tx_cnt <= r_tx_cnt + 4'd1;
            end

            // Output enables are registered so the open-drain lines never glitch.
            r_clk_oe  <= (tx_next == TX_INHIBIT);
            r_data_oe <= w_data_oe_next;

            r_rx_error    <= w_rx_bad | w_rx_to;
            r_rx_overflow <= w_push & w_full & ~w_pop;
            r_tx_done     <= w_tx_ok;
            r_tx_error    <= w_tx_fail;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_rx_shift[8:1];
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign rx_error    = r_rx_error;
    assign rx_overflow = r_rx_overflow;
    assign tx_done     = r_tx_done;
    assign tx_error    = r_tx_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host.sv
`default_nettype none
// Self-checking bench for ps2_host: behavioural PS/2 keyboard on wired-AND lines,
// expected results derived from the PS/2 framing rules.
module tb_ps2_host;

    localparam int DEB = 3;
    localparam int FL2 = 2;
    localparam int INH = 20;
    localparam int TO  = 2000;

    logic       clk       = 1'b0;
    logic       reset_low = 1'b0;
    logic       dev_clk   = 1'b1;
    logic       dev_data  = 1'b1;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       rx_ready  = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       rx_overflow;
    logic       tx_valid  = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_done;
    logic       tx_error;

    int tests = 0;
    int fails = 0;
    int n_rx_err = 0;
    int n_ovf = 0;
    int n_done = 0;
    int n_txerr = 0;

    assign ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_pin = dev_data & ~ps2_data_oe;

    ps2_host #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_LOG2      (FL2),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_low   (reset_low),
        .ps2_clk_pin (ps2_clk_pin),
        .ps2_data_pin(ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_ready    (rx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_error    (rx_error),
        .rx_overflow (rx_overflow),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_error)    n_rx_err++;
        if (rx_overflow) n_ovf++;
        if (tx_done)     n_done++;
        if (tx_error)    n_txerr++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip,
                                             input logic stop_bit);
        logic p;
        p = (($countones(d) % 2) == 0) ^ par_flip;
        return {stop_bit, p, d, 1'b0};
    endfunction

    function automatic bit frame_good(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
    endfunction

    // Device presents a bit, then pulses its clock low (30 system cycles per bit).
    task automatic dev_bit(input logic b);
        dev_data = b;
        cyc(8);
        dev_clk = 1'b0;
        cyc(15);
        dev_clk = 1'b1;
        cyc(7);
    endtask

    task automatic send_frame(input logic [10:0] f);
        for (int i = 0; i < 11; i++) dev_bit(f[i]);
        dev_data = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_tx(input logic [7:0] d, output bit ok);
        wait_tx_ready(ok);
        if (!ok) return;
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Device side of a host-to-device transfer; seen[0]=start .. seen[10]=stop.
    task automatic run_tx(input logic [7:0] d, input logic ack_low,
                          output logic [10:0] seen, output int inh, output bit ok);
        seen = '1;
        inh  = 0;
        start_tx(d, ok);
        if (!ok) return;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) inh++;
            else if (inh > 0) break;
        end
        if (inh == 0) begin
            ok = 1'b0;
            return;
        end
        cyc(10);
        seen[0] = ps2_data_pin;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            cyc(15);
            dev_clk = 1'b1;
            cyc(8);
            seen[k] = ps2_data_pin;
            cyc(7);
        end
        dev_data = ack_low ? 1'b0 : 1'b1;
        cyc(8);
        dev_clk = 1'b0;
        cyc(15);
        dev_clk = 1'b1;
        cyc(8);
        dev_data = 1'b1;
        cyc(10);
    endtask

    task automatic test_reset();
        cyc(3);
        @(negedge clk);
        tests++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
            $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        tests++;
        if ({rx_valid, rx_error, rx_overflow, tx_done, tx_error} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {rx_valid, rx_error, rx_overflow, tx_done, tx_error});
        end
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_tx_ready: got %b expected 0", tx_ready);
        end
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) fails++;
        @(posedge clk); #1;
        reset_low = 1'b1;
        cyc(2);
        @(negedge clk);
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_tx_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_rx_basic();
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1));
        cyc(5);
        @(negedge clk);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h1C) begin
            fails++;
            $display("FAIL rx_1c: got valid=%b data=%h expected valid=1 data=1c", rx_valid, rx_data);
        end
        pop_one();
        @(negedge clk);
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_pop: got valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_rx_parity_error();
        int e0;
        e0 = n_rx_err;
        send_frame(mk_frame(8'h1C, 1'b1, 1'b1));
        cyc(10);
        tests++;
        if (n_rx_err !== e0 + 1 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_parity: got errors=%0d valid=%b expected errors=%0d valid=0",
                     n_rx_err - e0, rx_valid, 1);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        int o0, exp_ovf;
        o0 = n_ovf;
        exp_ovf = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(mk_frame(8'(i), 1'b0, 1'b1));
            if (q.size() < (1 << FL2)) q.push_back(8'(i));
            else exp_ovf++;
        end
        cyc(10);
        tests++;
        if (n_ovf !== o0 + exp_ovf) begin
            fails++;
            $display("FAIL overflow_count: got %0d expected %0d", n_ovf - o0, exp_ovf);
        end
        while (q.size() > 0) begin
            logic [7:0] e;
            e = q.pop_front();
            @(negedge clk);
            tests++;
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                fails++;
                $display("FAIL fifo_order: got valid=%b data=%h expected valid=1 data=%h",
                         rx_valid, rx_data, e);
            end
            pop_one();
        end
        @(negedge clk);
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL fifo_drained: got valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_rx_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0]  d;
            logic [10:0] f;
            int          kind, e0;
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 4));
            f    = mk_frame(d, kind == 0, kind != 1);
            e0   = n_rx_err;
            send_frame(f);
            cyc(10);
            @(negedge clk);
            tests++;
            if (frame_good(f)) begin
                if (rx_valid !== 1'b1 || rx_data !== d || n_rx_err !== e0) begin
                    fails++;
                    $display("FAIL rx_random_good: got valid=%b data=%h errs=%0d expected valid=1 data=%h errs=0",
                             rx_valid, rx_data, n_rx_err - e0, d);
                end
                pop_one();
            end else begin
                if (rx_valid !== 1'b0 || n_rx_err !== e0 + 1) begin
                    fails++;
                    $display("FAIL rx_random_bad: got valid=%b errs=%0d expected valid=0 errs=1",
                             rx_valid, n_rx_err - e0);
                end
            end
        end
    endtask

    task automatic test_tx(input logic [7:0] d, input logic ack_low);
        logic [10:0] seen;
        int          inh, d0, x0, r0;
        bit          ok, rdy;
        d0 = n_done;
        x0 = n_txerr;
        r0 = n_rx_err;
        run_tx(d, ack_low, seen, inh, ok);
        tests++;
        if (!ok || inh != INH) begin
            fails++;
            $display("FAIL tx_inhibit: got ok=%b cycles=%0d expected ok=1 cycles=%0d", ok, inh, INH);
        end
        tests++;
        if (seen[0] !== 1'b0 || seen[10] !== 1'b1) begin
            fails++;
            $display("FAIL tx_framing: got start=%b stop=%b expected start=0 stop=1", seen[0], seen[10]);
        end
        tests++;
        if (seen[8:1] !== d || seen[9] !== (($countones(d) % 2) == 0)) begin
            fails++;
            $display("FAIL tx_byte: got data=%h par=%b expected data=%h par=%b",
                     seen[8:1], seen[9], d, (($countones(d) % 2) == 0));
        end
        tests++;
        if (n_done !== d0 + (ack_low ? 1 : 0) || n_txerr !== x0 + (ack_low ? 0 : 1)) begin
            fails++;
            $display("FAIL tx_result: got done=%0d err=%0d expected done=%0d err=%0d",
                     n_done - d0, n_txerr - x0, ack_low ? 1 : 0, ack_low ? 0 : 1);
        end
        wait_tx_ready(rdy);
        tests++;
        if (rdy !== 1'b1 || n_rx_err !== r0 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL tx_return_idle: got ready=%b rx_errs=%0d valid=%b expected ready=1 rx_errs=0 valid=0",
                     rdy, n_rx_err - r0, rx_valid);
        end
    endtask

    task automatic test_rx_timeout();
        logic [10:0] f;
        int          el, e0;
        bit          got;
        e0 = n_rx_err;
        f  = mk_frame(8'hAA, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) dev_bit(f[i]);
        dev_data = 1'b1;
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL tx_ready_mid_rx: got %b expected 0", tx_ready);
        end
        el  = 22;
        got = 1'b0;
        for (int i = 0; i < 2300; i++) begin
            @(negedge clk);
            el++;
            if (rx_error) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got || el < TO - 5 || el > TO + 25) begin
            fails++;
            $display("FAIL rx_timeout: got seen=%b after %0d cycles expected seen=1 after ~%0d",
                     got, el, TO);
        end
        cyc(5);
        tests++;
        if (n_rx_err !== e0 + 1 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_timeout_count: got errs=%0d valid=%b expected errs=1 valid=0",
                     n_rx_err - e0, rx_valid);
        end
        send_frame(f);
        cyc(5);
        @(negedge clk);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hAA) begin
            fails++;
            $display("FAIL rx_after_timeout: got valid=%b data=%h expected valid=1 data=aa",
                     rx_valid, rx_data);
        end
        pop_one();
    endtask

    task automatic test_reset_mid_tx();
        bit ok, seen_oe;
        start_tx(8'($urandom), ok);
        cyc(5);
        @(negedge clk);
        tests++;
        if (!ok || ps2_clk_oe !== 1'b1) begin
            fails++;
            $display("FAIL inhibit_active: got ok=%b clk_oe=%b expected ok=1 clk_oe=1", ok, ps2_clk_oe);
        end
        #2 reset_low = 1'b0;
        #1;
        tests++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            fails++;
            $display("FAIL reset_in_inhibit: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        @(posedge clk); #1;
        reset_low = 1'b1;

        start_tx(8'($urandom), ok);
        seen_oe = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) seen_oe = 1'b1;
            else if (seen_oe && ps2_data_oe) break;
        end
        tests++;
        if (!ok || ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin
            fails++;
            $display("FAIL tx_request: got clk_oe=%b data_oe=%b expected clk_oe=0 data_oe=1",
                     ps2_clk_oe, ps2_data_oe);
        end
        #2 reset_low = 1'b0;
        #1;
        tests++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            fails++;
            $display("FAIL reset_in_tx: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        @(posedge clk); #1;
        reset_low = 1'b1;
        wait_tx_ready(ok);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b expected 1", ok);
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_parity_error();
        test_overflow();
        test_rx_random();
        test_tx(8'hED, 1'b1);
        test_tx(8'hED, 1'b0);
        test_tx(8'($urandom), 1'b1);
        test_rx_timeout();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
